dyn_phase_pll_resp: RTL and testbench

PLL-side responder for the dynamic phase-shift handshake driven by the phase-step state machine. It samples PHASECOUNTERSELECT, PHASEUPDOWN and PHASESTEP, answers with PHASEDONE using the PLL's timing rules, and accumulates a signed phase offset for each counter. It is used in place of the PLL in simulation and on-chip loopback tests. It also checks the initiator for protocol errors.

---
 rtl/dyn_phase_pll_resp_if.sv | 23 ++
 rtl/dyn_phase_pll_resp.sv | 145 ++++++++++++++
 tb/tb_dyn_phase_pll_resp.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dyn_phase_pll_resp_if.sv
// Dynamic phase-shift handshake between the phase-step initiator and the PLL
// side.
//   PHASECOUNTERSELECT : counter select (0 = all C, 1 = M, 2+n = Cn)
//   PHASEUPDOWN        : 1 = step up, 0 = step down
//   PHASESTEP          : step request level
//   PHASEDONE          : high = idle, low = shift in progress
// master = initiator (phase-step state machine), slave = PLL responder.
interface dyn_phase_pll_resp_if;
  logic [3:0] PHASECOUNTERSELECT;
  logic       PHASEUPDOWN;
  logic       PHASESTEP;
  logic       PHASEDONE;

  modport master (
    output PHASECOUNTERSELECT, PHASEUPDOWN, PHASESTEP,
    input  PHASEDONE
  );

  modport slave (
    input  PHASECOUNTERSELECT, PHASEUPDOWN, PHASESTEP,
    output PHASEDONE
  );
endinterface

// File: rtl/dyn_phase_pll_resp.sv
// PLL-side responder for the dynamic phase-shift handshake. It accepts a step
// once PHASESTEP has been held for P_STEP_MIN samples, holds PHASEDONE low for
// P_DONE_LAT cycles, then applies a +/-1 update to the selected counter offset
// and counts the step. It also flags short requests and illegal selects.
// Ports:
//   CLK50M, RESET : single clock, synchronous active-high reset
//   ph            : handshake interface (slave side)
//   CLR_ERR       : one-cycle pulse clearing the sticky error flags
//   PHASE_M       : M-counter offset
//   PHASE_C       : packed C-counter offsets, Cn at [n*P_PHASE_W +: P_PHASE_W]
//   STEP_COUNT    : completed steps (wraps)
//   ERR_SHORT     : sticky, PHASESTEP released before P_STEP_MIN samples
//   ERR_SEL       : sticky, a step completed with an illegal select
module dyn_phase_pll_resp #(
  parameter int unsigned P_NUM_CNT  = 5,
  parameter int unsigned P_PHASE_W  = 8,
  parameter int unsigned P_STEP_MIN = 2,
  parameter int unsigned P_DONE_LAT = 4
) (
  input  logic                            CLK50M,
  input  logic                            RESET,
  dyn_phase_pll_resp_if.slave             ph,
  input  logic                            CLR_ERR,
  output logic [P_PHASE_W-1:0]            PHASE_M,
  output logic [P_NUM_CNT*P_PHASE_W-1:0]  PHASE_C,
  output logic [15:0]                     STEP_COUNT,
  output logic                            ERR_SHORT,
  output logic                            ERR_SEL
);
  localparam int unsigned HOLD_W = $clog2(P_STEP_MIN + 1);
  localparam int unsigned BUSY_W = $clog2(P_DONE_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_BUSY, S_WAIT_REL} state_t;

  state_t              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [BUSY_W-1:0]   busy_q, busy_d;
  logic [3:0]          sel_q, sel_d;
  logic                ud_q, ud_d;
  logic                done_q, done_d;
  logic                apply;
  logic                short_evt;
  logic                sel_legal;
  logic [P_PHASE_W-1:0] delta;

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      busy_q  <= '0;
      sel_q   <= '0;
      ud_q    <= 1'b0;
      done_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      ud_q    <= ud_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    sel_d     = sel_q;
    ud_d      = ud_q;
    done_d    = done_q;
    apply     = 1'b0;
    short_evt = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ph.PHASESTEP) begin
          sel_d  = ph.PHASECOUNTERSELECT;
          ud_d   = ph.PHASEUPDOWN;
          hold_d = HOLD_W'(1);
          if (P_STEP_MIN == 1) begin
            state_d = S_BUSY;
            busy_d  = BUSY_W'(P_DONE_LAT);
            done_d  = 1'b0;
          end else begin
            state_d = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (ph.PHASESTEP) begin
          if (32'(hold_q) + 1 >= P_STEP_MIN) begin
            state_d = S_BUSY;
            busy_d  = BUSY_W'(P_DONE_LAT);
            done_d  = 1'b0;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end else begin
          short_evt = 1'b1;
          state_d   = S_IDLE;
          hold_d    = '0;
        end
      end
      S_BUSY: begin
        busy_d = busy_q - 1'b1;
        // Last busy cycle: the update and PHASEDONE rise share this edge.
        if (busy_q == BUSY_W'(1)) begin
          apply   = 1'b1;
          done_d  = 1'b1;
          state_d = ph.PHASESTEP ? S_WAIT_REL : S_IDLE;
        end
      end
      S_WAIT_REL: begin
        if (!ph.PHASESTEP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ph.PHASEDONE = done_q;
  assign delta        = ud_q ? P_PHASE_W'(1) : '1;
  assign sel_legal    = 32'(sel_q) < P_NUM_CNT + 2;

  always_ff @(posedge CLK50M) begin
    if (RESET) begin
      PHASE_M    <= '0;
      PHASE_C    <= '0;
      STEP_COUNT <= '0;
      ERR_SHORT  <= 1'b0;
      ERR_SEL    <= 1'b0;
    end else begin
      if (apply) begin
        STEP_COUNT <= STEP_COUNT + 16'd1;
        if (sel_q == 4'd1) PHASE_M <= PHASE_M + delta;
        for (int unsigned n = 0; n < P_NUM_CNT; n++) begin
          if (sel_q == 4'd0 || 32'(sel_q) == n + 2)
            PHASE_C[n*P_PHASE_W +: P_PHASE_W] <= PHASE_C[n*P_PHASE_W +: P_PHASE_W] + delta;
        end
      end
      // A new error event on the same edge as CLR_ERR keeps the flag set.
      ERR_SHORT <= short_evt | (ERR_SHORT & ~CLR_ERR);
      ERR_SEL   <= (apply & ~sel_legal) | (ERR_SEL & ~CLR_ERR);
    end
  end
endmodule

// File: tb/tb_dyn_phase_pll_resp.sv
module tb_dyn_phase_pll_resp;
  localparam int unsigned NC   = 5;
  localparam int unsigned PW   = 8;
  localparam int unsigned SMIN = 2;
  localparam int unsigned DLAT = 4;
  localparam int          MASK = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [PW-1:0]    phase_m;
  logic [NC*PW-1:0] phase_c;
  logic [15:0]      step_count;
  logic             err_short, err_sel;

  always #10 clk = ~clk;

  dyn_phase_pll_resp_if ph();

  dyn_phase_pll_resp #(
    .P_NUM_CNT (NC),
    .P_PHASE_W (PW),
    .P_STEP_MIN(SMIN),
    .P_DONE_LAT(DLAT)
  ) dut (
    .CLK50M    (clk),
    .RESET     (rst),
    .ph        (ph),
    .CLR_ERR   (clr),
    .PHASE_M   (phase_m),
    .PHASE_C   (phase_c),
    .STEP_COUNT(step_count),
    .ERR_SHORT (err_short),
    .ERR_SEL   (err_sel)
  );

  int checks = 0;
  int passes = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Reference model: a request is a run of high samples; after SMIN of them
  // the responder is busy for DLAT cycles, then must see a low sample.
  int m_busy, m_run, m_sel, m_m, m_cnt;
  int m_c[NC];
  bit m_ud, m_wait, m_es, m_esel;

  always @(posedge clk) begin
    bit set_s, set_sel;
    int d;
    set_s   = 1'b0;
    set_sel = 1'b0;
    if (rst) begin
      m_busy = 0; m_run = 0; m_sel = 0; m_m = 0; m_cnt = 0;
      m_ud = 0; m_wait = 0; m_es = 0; m_esel = 0;
      foreach (m_c[i]) m_c[i] = 0;
    end else begin
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          d = m_ud ? 1 : -1;
          if (m_sel == 0) foreach (m_c[i]) m_c[i] = (m_c[i] + d) & MASK;
          else if (m_sel == 1) m_m = (m_m + d) & MASK;
          else if (m_sel - 2 < NC) m_c[m_sel-2] = (m_c[m_sel-2] + d) & MASK;
          else set_sel = 1'b1;
          m_cnt  = (m_cnt + 1) & 16'hFFFF;
          m_wait = ph.PHASESTEP;
        end
      end else if (m_wait) begin
        if (!ph.PHASESTEP) m_wait = 0;
      end else if (ph.PHASESTEP) begin
        if (m_run == 0) begin
          m_sel = int'(ph.PHASECOUNTERSELECT);
          m_ud  = ph.PHASEUPDOWN;
        end
        m_run++;
        if (m_run >= SMIN) begin
          m_busy = DLAT;
          m_run  = 0;
        end
      end else begin
        if (m_run > 0) set_s = 1'b1;
        m_run = 0;
      end
      m_es   = set_s   | (m_es   & !clr);
      m_esel = set_sel | (m_esel & !clr);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("done", ph.PHASEDONE, (m_busy == 0) ? 1 : 0);
      chk("phase_m", phase_m, m_m);
      for (int i = 0; i < NC; i++) chk("phase_c", phase_c[i*PW +: PW], m_c[i]);
      chk("step_count", step_count, m_cnt);
      chk("err_short", err_short, m_es);
      chk("err_sel", err_sel, m_esel);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    ph.PHASESTEP = 1'b0;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_step(int sel, bit up, int hi);
    ph.PHASECOUNTERSELECT = 4'(sel);
    ph.PHASEUPDOWN        = up;
    ph.PHASESTEP          = 1'b1;
    cyc(hi);
    ph.PHASESTEP = 1'b0;
    cyc(1);
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (!ph.PHASEDONE && n < 20) begin
      cyc(1);
      n++;
    end
    if (n >= 20) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic step_and_wait(int sel, bit up, int hi);
    pulse_step(sel, up, hi);
    wait_done("step");
  endtask

  // Initiator-style handshake: hold the request until PHASEDONE falls.
  task automatic hs_step(int sel, bit up);
    int n = 0;
    ph.PHASECOUNTERSELECT = 4'(sel);
    ph.PHASEUPDOWN        = up;
    ph.PHASESTEP          = 1'b1;
    while (ph.PHASEDONE && n < 20) begin
      cyc(1);
      n++;
    end
    if (n >= 20) chk("hs_fall_timeout", 0, 1);
    ph.PHASESTEP = 1'b0;
    wait_done("hs_rise");
    cyc(1);
  endtask

  initial begin
    int lows;
    ph.PHASECOUNTERSELECT = '0;
    ph.PHASEUPDOWN        = 1'b0;
    ph.PHASESTEP          = 1'b0;
    cyc(2);
    rst = 1'b0;

    // Reset / idle
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk("idle_done", ph.PHASEDONE, 1);
      chk("idle_cnt", step_count, 0);
      chk("idle_c", phase_c, 0);
      chk("idle_flags", {err_short, err_sel}, 0);
    end

    // Single step, C1 up, held 6 cycles
    ph.PHASECOUNTERSELECT = 4'h3;
    ph.PHASEUPDOWN        = 1'b1;
    ph.PHASESTEP          = 1'b1;
    lows = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1);
      if (!ph.PHASEDONE) lows++;
      if (k == 0) chk("done_after_e0", ph.PHASEDONE, 1);
      if (k == 1) chk("done_after_e1", ph.PHASEDONE, 0);
      if (k == 5) chk("done_after_e5", ph.PHASEDONE, 1);
    end
    ph.PHASESTEP = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      if (!ph.PHASEDONE) lows++;
    end
    chk("single_low_cycles", lows, 4);
    chk("single_c1", phase_c[15:8], 8'h01);
    chk("single_c_rest", {phase_c[39:16], phase_c[7:0]}, 0);
    chk("single_m", phase_m, 0);
    chk("single_cnt", step_count, 1);

    // Broadcast down from reset, then M up x128
    do_reset();
    step_and_wait(0, 0, 2);
    chk("bcast_c", phase_c, 40'hFFFFFFFFFF);
    for (int k = 0; k < 128; k++) step_and_wait(1, 1, 2);
    chk("wrap_m", phase_m, 8'h80);
    chk("wrap_cnt", step_count, 129);

    // Short request
    pulse_step(2, 1, 1);
    cyc(2);
    chk("short_flag", err_short, 1);
    chk("short_cnt", step_count, 129);
    chk("short_c", phase_c, 40'hFFFFFFFFFF);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_short", err_short, 0);

    // CLR_ERR on the same edge as a new short-step error
    ph.PHASECOUNTERSELECT = 4'h2;
    ph.PHASESTEP = 1'b1;
    cyc(1);
    ph.PHASESTEP = 1'b0;
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("clr_vs_set", err_short, 1);

    // Illegal select
    step_and_wait(9, 1, 2);
    chk("sel_flag", err_sel, 1);
    chk("sel_cnt", step_count, 130);
    chk("sel_m", phase_m, 8'h80);
    chk("sel_c", phase_c, 40'hFFFFFFFFFF);

    // Reset in the 2nd low cycle of PHASEDONE
    do_reset();
    ph.PHASECOUNTERSELECT = 4'h2;
    ph.PHASEUPDOWN = 1'b1;
    ph.PHASESTEP   = 1'b1;
    lows = 0;
    while (ph.PHASEDONE && lows < 10) begin
      cyc(1);
      lows++;
    end
    chk("busy_seen", ph.PHASEDONE, 0);
    cyc(1);
    ph.PHASESTEP = 1'b0;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_done", ph.PHASEDONE, 1);
    chk("midrst_cnt", step_count, 0);
    chk("midrst_c", phase_c, 0);
    cyc(2);
    step_and_wait(2, 1, 2);
    chk("after_rst_c0", phase_c[7:0], 8'h01);
    chk("after_rst_cnt", step_count, 1);

    // Initiator loopback: 3 up-steps to C0
    do_reset();
    for (int k = 0; k < 3; k++) hs_step(2, 1);
    chk("loop_c0", phase_c[7:0], 8'h03);
    chk("loop_cnt", step_count, 3);
    chk("loop_flags", {err_short, err_sel}, 0);

    // Randomized runs against the model
    for (int k = 0; k < 400; k++) begin
      int len;
      ph.PHASESTEP          = 1'($urandom_range(0, 1));
      ph.PHASECOUNTERSELECT = 4'($urandom_range(0, 15));
      ph.PHASEUPDOWN        = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        clr = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 199) == 0);
        cyc(1);
      end
    end
    clr = 1'b0;
    rst = 1'b0;
    ph.PHASESTEP = 1'b0;
    cyc(10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
